// File: rtl/vga_text_pkg.sv
// Shared constants, FSM states and cursor commands for the VGA text write path.
package vga_text_pkg;

  localparam int unsigned COLS_DEFAULT = 80;
  localparam int unsigned ROWS_DEFAULT = 30;

  localparam logic [7:0] CH_NUL      = 8'h00;
  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StClearRow,
    StClearAll
  } state_e;

  typedef enum logic [2:0] {
    CmdNone,
    CmdInc,
    CmdDec,
    CmdCr,
    CmdNewline,
    CmdHome
  } cursor_cmd_e;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= CH_PRINT_LO) && (ch <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_cursor_counter.sv
// Cursor position (col, row) plus a running row base address; the linear
// address is row_base + col, so no multiplier is needed.
module text_cursor_counter
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEFAULT,
  parameter int unsigned ROWS   = ROWS_DEFAULT,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  cursor_cmd_e       i_cmd,
  output logic [6:0]        o_col,
  output logic [4:0]        o_row,
  output logic [ADDR_W-1:0] o_row_base,
  output logic [ADDR_W-1:0] o_next_base,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W-1:0] o_prev_addr
);

  localparam logic [6:0]        LastCol = 7'(COLS - 1);
  localparam logic [4:0]        LastRow = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(COLS);

  logic [6:0]        r_col, w_col_d;
  logic [4:0]        r_row, w_row_d, w_next_row;
  logic [ADDR_W-1:0] r_base, w_base_d, w_next_base;
  logic              w_wrap;

  assign w_wrap      = (r_row == LastRow);
  assign w_next_row  = w_wrap ? '0 : r_row + 5'd1;
  assign w_next_base = w_wrap ? '0 : r_base + RowStep;

  always_comb begin
    w_col_d  = r_col;
    w_row_d  = r_row;
    w_base_d = r_base;
    case (i_cmd)
      CmdInc: begin
        if (r_col == LastCol) begin
          w_col_d  = '0;
          w_row_d  = w_next_row;
          w_base_d = w_next_base;
        end else begin
          w_col_d = r_col + 7'd1;
        end
      end
      CmdDec: begin
        if (r_col != '0) w_col_d = r_col - 7'd1;
      end
      CmdCr: w_col_d = '0;
      CmdNewline: begin
        w_col_d  = '0;
        w_row_d  = w_next_row;
        w_base_d = w_next_base;
      end
      CmdHome: begin
        w_col_d  = '0;
        w_row_d  = '0;
        w_base_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_base <= '0;
    end else begin
      r_col  <= w_col_d;
      r_row  <= w_row_d;
      r_base <= w_base_d;
    end
  end

  assign o_col       = r_col;
  assign o_row       = r_row;
  assign o_row_base  = r_base;
  assign o_next_base = w_next_base;
  assign o_addr      = r_base + ADDR_W'(r_col);
  assign o_prev_addr = o_addr - ADDR_W'(1);

endmodule

// File: rtl/text_cursor_ctrl.sv
// Byte-stream to text-buffer write controller with clear-row/clear-screen sweeps.
// Optional TEXT_CURSOR_DEDUP_EN suppresses repeats of the last printable byte.
module text_cursor_ctrl
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEFAULT,
  parameter int unsigned ROWS   = ROWS_DEFAULT,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [6:0]        o_cursor_col,
  output logic [4:0]        o_cursor_row,
  output logic              o_busy
);

  localparam int unsigned        SweepW     = ADDR_W + 1;
  localparam logic [SweepW-1:0]  TotalCells = SweepW'(COLS * ROWS);
  localparam logic [SweepW-1:0]  RowCells   = SweepW'(COLS);
  localparam logic [6:0]         LastCol    = 7'(COLS - 1);

  state_e            r_state, w_state_d;
  logic [7:0]        r_byte, w_byte_d;
  logic [SweepW-1:0] r_sweep, w_sweep_d;
  logic              r_rx_ready, r_wr_en, w_wr_en_d, r_busy;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_d;
  logic [7:0]        r_wr_data, w_wr_data_d;

  cursor_cmd_e       w_cmd;
  logic [6:0]        w_col;
  logic [4:0]        w_row;
  logic [ADDR_W-1:0] w_row_base, w_next_base, w_addr, w_prev_addr;
  logic              w_accept, w_dup;
  logic [7:0]        w_in_byte;

  assign w_accept = r_rx_ready & i_rx_valid;

`ifdef TEXT_CURSOR_DEDUP_EN
  logic [7:0] r_last, w_last_d;

  assign w_dup = is_printable(i_rx_data) && (i_rx_data == r_last);

  always_comb begin
    w_last_d = r_last;
    if (w_accept) w_last_d = is_printable(i_rx_data) ? i_rx_data : CH_NUL;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_last <= CH_NUL;
    else       r_last <= w_last_d;
  end
`else
  assign w_dup = 1'b0;
`endif

  // A suppressed duplicate is latched as NUL so EXEC treats it as a no-op.
  assign w_in_byte = w_dup ? CH_NUL : i_rx_data;

  text_cursor_counter #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd       (w_cmd),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_row_base  (w_row_base),
    .o_next_base (w_next_base),
    .o_addr      (w_addr),
    .o_prev_addr (w_prev_addr)
  );

  // Outputs are registered from next-state decisions, so the write for a
  // state is issued on the edge that enters it.
  always_comb begin
    w_state_d   = r_state;
    w_byte_d    = r_byte;
    w_sweep_d   = r_sweep;
    w_wr_en_d   = 1'b0;
    w_wr_addr_d = r_wr_addr;
    w_wr_data_d = CH_SPACE;
    w_cmd       = CmdNone;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StExec;
          w_byte_d  = w_in_byte;
          if (is_printable(w_in_byte)) begin
            w_wr_en_d   = 1'b1;
            w_wr_addr_d = w_addr;
            w_wr_data_d = w_in_byte;
          end else if ((w_in_byte == CH_BS) && (w_col != '0)) begin
            w_wr_en_d   = 1'b1;
            w_wr_addr_d = w_prev_addr;
          end
        end
      end
      StExec: begin
        w_state_d = StIdle;
        if (is_printable(r_byte)) begin
          w_cmd = CmdInc;
          if (w_col == LastCol) begin
            w_state_d   = StClearRow;
            w_wr_en_d   = 1'b1;
            w_wr_addr_d = w_next_base;
            w_sweep_d   = SweepW'(1);
          end
        end else begin
          case (r_byte)
            CH_CR: w_cmd = CmdCr;
            CH_LF: begin
              w_cmd       = CmdNewline;
              w_state_d   = StClearRow;
              w_wr_en_d   = 1'b1;
              w_wr_addr_d = w_next_base;
              w_sweep_d   = SweepW'(1);
            end
            CH_BS: w_cmd = CmdDec;
            CH_FF: begin
              w_state_d   = StClearAll;
              w_wr_en_d   = 1'b1;
              w_wr_addr_d = '0;
              w_sweep_d   = SweepW'(1);
            end
            default: ;
          endcase
        end
      end
      StClearRow: begin
        if (r_sweep == RowCells) begin
          w_state_d = StIdle;
        end else begin
          w_wr_en_d   = 1'b1;
          w_wr_addr_d = w_row_base + ADDR_W'(r_sweep);
          w_sweep_d   = r_sweep + SweepW'(1);
        end
      end
      StClearAll: begin
        if (r_sweep == TotalCells) begin
          w_state_d = StIdle;
          w_cmd     = CmdHome;
        end else begin
          w_wr_en_d   = 1'b1;
          w_wr_addr_d = ADDR_W'(r_sweep);
          w_sweep_d   = r_sweep + SweepW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StClearAll;
      r_byte     <= CH_NUL;
      r_sweep    <= '0;
      r_rx_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= CH_SPACE;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_byte     <= w_byte_d;
      r_sweep    <= w_sweep_d;
      r_rx_ready <= (w_state_d == StIdle);
      r_wr_en    <= w_wr_en_d;
      r_wr_addr  <= w_wr_addr_d;
      r_wr_data  <= w_wr_data_d;
      r_busy     <= (w_state_d == StClearRow) || (w_state_d == StClearAll);
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_cursor_col = w_col;
  assign o_cursor_row = w_row;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed self-checking bench for text_cursor_ctrl (80x30 grid).
module tb_text_cursor_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  text_cursor_ctrl #(
    .COLS   (80),
    .ROWS   (30),
    .ADDR_W (12)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_ready   (rx_ready),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_cursor_col (cursor_col),
    .o_cursor_row (cursor_row),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for rx_ready, presents the byte for one accepting edge and
  // returns in the EXEC cycle.
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (rx_ready !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, rx_ready}, 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rx_ready === 1'b1 && busy === 1'b0) && n < 5000) begin
      tick();
      n++;
    end
    chk("idle_wait", {31'd0, rx_ready & ~busy}, 32'd1);
  endtask

  // Expects to be entered in the cycle showing the write to address 0.
  task automatic full_sweep(input string tag);
    int bad = 0;
    for (int k = 0; k < 2400; k++) begin
      if (!(wr_en === 1'b1 && wr_addr === 12'(k) && wr_data === 8'h20 && busy === 1'b1)) bad++;
      tick();
    end
    chk({tag, "_bad_cycles"}, bad, 0);
    chk({tag, "_wr_en_after"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, rx_ready}, 32'd1);
    chk({tag, "_col"}, {25'd0, cursor_col}, 32'd0);
    chk({tag, "_row"}, {27'd0, cursor_row}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int nw;
    int exp_nw;
    int exp_col;

    // Reset values
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {20'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'h20);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_col", {25'd0, cursor_col}, 32'd0);
    chk("rst_row", {27'd0, cursor_row}, 32'd0);
    rst = 1'b0;
    tick();
    full_sweep("boot");

    // 'A' then 'B'
    send(8'h41);
    chk("A_wr_en", {31'd0, wr_en}, 32'd1);
    chk("A_addr", {20'd0, wr_addr}, 32'd0);
    chk("A_data", {24'd0, wr_data}, 32'h41);
    chk("A_ready_exec", {31'd0, rx_ready}, 32'd0);
    send(8'h42);
    chk("B_wr_en", {31'd0, wr_en}, 32'd1);
    chk("B_addr", {20'd0, wr_addr}, 32'd1);
    chk("B_data", {24'd0, wr_data}, 32'h42);
    tick();
    chk("AB_col", {25'd0, cursor_col}, 32'd2);
    chk("AB_ready", {31'd0, rx_ready}, 32'd1);

    // Walk to (79,29) and overflow the last cell
    send(8'h0D);
    for (int i = 0; i < 29; i++) begin
      send(8'h0A);
      wait_idle();
    end
    chk("lf_row", {27'd0, cursor_row}, 32'd29);
    for (int i = 0; i < 79; i++) send((i % 2 == 0) ? 8'h61 : 8'h62);
    tick();
    chk("end_col", {25'd0, cursor_col}, 32'd79);
    chk("end_row", {27'd0, cursor_row}, 32'd29);
    send(8'h5A);
    chk("last_wr_en", {31'd0, wr_en}, 32'd1);
    chk("last_addr", {20'd0, wr_addr}, 32'd2399);
    chk("last_data", {24'd0, wr_data}, 32'h5A);
    tick();
    chk("wrap_col", {25'd0, cursor_col}, 32'd0);
    chk("wrap_row", {27'd0, cursor_row}, 32'd0);
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      if (!(wr_en === 1'b1 && wr_addr === 12'(k) && wr_data === 8'h20 && busy === 1'b1)) bad++;
      tick();
    end
    chk("rowclr_bad_cycles", bad, 0);
    chk("rowclr_wr_en_after", {31'd0, wr_en}, 32'd0);
    chk("rowclr_busy_after", {31'd0, busy}, 32'd0);
    chk("rowclr_ready_after", {31'd0, rx_ready}, 32'd1);

    // 'X', BS, BS
    send(8'h58);
    chk("X_addr", {20'd0, wr_addr}, 32'd0);
    tick();
    chk("X_col", {25'd0, cursor_col}, 32'd1);
    send(8'h08);
    chk("bs1_wr_en", {31'd0, wr_en}, 32'd1);
    chk("bs1_addr", {20'd0, wr_addr}, 32'd0);
    chk("bs1_data", {24'd0, wr_data}, 32'h20);
    tick();
    chk("bs1_col", {25'd0, cursor_col}, 32'd0);
    send(8'h08);
    chk("bs2_wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    chk("bs2_col", {25'd0, cursor_col}, 32'd0);

    // FF at (5,3), reset in the middle of the sweep
    for (int i = 0; i < 3; i++) begin
      send(8'h0A);
      wait_idle();
    end
    for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 8'h70 : 8'h71);
    tick();
    chk("ff_pre_col", {25'd0, cursor_col}, 32'd5);
    chk("ff_pre_row", {27'd0, cursor_row}, 32'd3);
    send(8'h0C);
    chk("ff_exec_wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    bad = 0;
    for (int k = 0; k < 1200; k++) begin
      if (!(wr_en === 1'b1 && wr_addr === 12'(k) && busy === 1'b1)) bad++;
      tick();
    end
    chk("ff_half_bad_cycles", bad, 0);
    chk("ff_half_col_held", {25'd0, cursor_col}, 32'd5);
    rst = 1'b1;
    tick();
    chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_col", {25'd0, cursor_col}, 32'd0);
    chk("midrst_row", {27'd0, cursor_row}, 32'd3 - 32'd3);
    rst = 1'b0;
    tick();
    full_sweep("ffrst");

    // Repeated printable bytes
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h41);
      nw += int'(wr_en);
    end
    tick();
`ifdef TEXT_CURSOR_DEDUP_EN
    exp_nw  = 1;
    exp_col = 1;
`else
    exp_nw  = 3;
    exp_col = 3;
`endif
    chk("AAA_writes", nw, exp_nw);
    chk("AAA_col", {25'd0, cursor_col}, exp_col);

    send(8'h0D);
    nw = 0;
    send(8'h41);
    nw += int'(wr_en);
    chk("ACA_first_addr", {20'd0, wr_addr}, 32'd0);
    send(8'h0D);
    send(8'h41);
    nw += int'(wr_en);
    chk("ACA_second_addr", {20'd0, wr_addr}, 32'd0);
    chk("ACA_writes", nw, 2);
    tick();
    chk("ACA_col", {25'd0, cursor_col}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
